// File: rtl/div_sec_32_if.sv
// Request/result bundle for the sequential restoring divider.
// The master drives start and operands; the slave returns status and results.
interface div_sec_32_if #(
    parameter int N = 32
);
    logic         st;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         done;
    logic         busy;
    logic         div_by_zero;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    modport master (
        output st, dividend, divisor,
        input  done, busy, div_by_zero, quotient, remainder
    );

    modport slave (
        input  st, dividend, divisor,
        output done, busy, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/div_sec_32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, one-cycle done pulse,
// results held until the next accepted start. A zero divisor short-circuits straight to DONE.
module div_sec_32 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_sec_32_if.slave    bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N:0]   acc_q, acc_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [2*N:0]   sh;
    logic [N+1:0]   sub;
    logic           borrow;
    logic [N:0]     diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        // One extra bit on the subtraction exposes the borrow of the (N+1)-bit trial difference.
        sh     = acc_q << 1;
        sub    = {1'b0, sh[2*N:N]} - {2'b00, dvs_q};
        borrow = sub[N+1];
        diff   = sub[N:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.st) begin
                    if (bus.divisor != '0) begin
                        acc_d   = {{(N+1){1'b0}}, bus.dividend};
                        dvs_d   = bus.divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                acc_d = borrow ? sh : {diff, sh[N-1:1], 1'b1};
                cnt_d = cnt_q + 1'b1;
                quo_d = acc_d[N-1:0];
                rem_d = acc_d[2*N-1:N];
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.done        = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
endmodule

// File: tb/tb_div_sec_32.sv
// Directed bench for div_sec_32: latency, results, zero divisor, held start, mid-run reset,
// plus a short batch of random pairs checked against / and %.
module tb_div_sec_32;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_sec_32_if #(.N(N)) bus ();

    div_sec_32 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Start one division, then wait (bounded) for done and check timing and results.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz);
        int   k;
        logic busy_ok;
        @(negedge clk);
        bus.st       = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.st       = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        k       = 0;
        busy_ok = 1'b1;
        while (!bus.done && k < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok & bus.busy), 64'd1);
        chk({tag, "_q"}, 64'(bus.quotient), 64'(eq));
        chk({tag, "_r"}, 64'(bus.remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          k;
        int          ndone;
        int          seen;
        logic [31:0] gq, gr, ra, rb;

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.st       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        chk("rst_q", 64'(bus.quotient), 64'd0);
        chk("rst_r", 64'(bus.remainder), 64'd0);

        run_div("d100_7", 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);
        run_div("max_1", 32'hFFFF_FFFF, 32'd1, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'd1, 32'd0, 1'b0);
        run_div("d5_9", 32'd5, 32'd9, 32, 32'd0, 32'd5, 1'b0);
        run_div("dz1234", 32'd1234, 32'd0, 0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        run_div("d0_3", 32'd0, 32'd3, 32, 32'd0, 32'd0, 1'b0);
        run_div("big_odd", 32'h8000_0001, 32'h0001_0000, 32, 32'h0000_8000, 32'd1, 1'b0);

        // Start held high throughout; operands change after acceptance.
        @(negedge clk);
        bus.st       = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'd3;
        ndone = 0;
        gq    = '0;
        gr    = '0;
        for (int i = 0; i < 33; i++) begin
            if (bus.done) begin
                ndone++;
                gq           = bus.quotient;
                gr           = bus.remainder;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd6;
            end
            @(negedge clk);
        end
        chk("hold_ndone", 64'(ndone), 64'd1);
        chk("hold_q", 64'(gq), 64'd14);
        chk("hold_r", 64'(gr), 64'd2);
        chk("hold_idle_done", 64'(bus.done), 64'd0);
        chk("hold_idle_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.st = 1'b0;
        k = 0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("hold2_lat", 64'(k), 64'd32);
        chk("hold2_q", 64'(bus.quotient), 64'd8);
        chk("hold2_r", 64'(bus.remainder), 64'd2);
        @(negedge clk);

        // Reset in the middle of a division aborts it.
        @(negedge clk);
        bus.st       = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.st = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_q", 64'(bus.quotient), 64'd0);
        chk("abort_r", 64'(bus.remainder), 64'd0);
        chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_div("after_abort", 32'd1000, 32'd7, 32, 32'd142, 32'd6, 1'b0);

        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd1;
            run_div("rand", ra, rb, 32, ra / rb, ra % rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
